wled_stream: RTL and testbench

- Parametrised WS2812/SK6812 strip driver. It combines per-LED colour selection with the serial bit encoder in one block.
- Per-LED green/red/blue enable bits and a runtime brightness level are captured once per frame. They are serialised as 24-bit (RGB) or 32-bit (RGBW) pixels, MSB first, followed by a latch gap.
- Sits between the plugin's register interface and the strip data pin. It replaces the separate pixel-compose and encoder blocks.

---
 rtl/wled_stream.sv | 195 +++++++++++++++++++
 tb/tb_wled_stream.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wled_stream.sv
// wled_stream: WS2812/SK6812 strip driver.
//
// Captures per-LED green/red/blue/white enable bits and a brightness level
// once per frame. Each LED becomes a 24-bit (GRB or RGB) or 32-bit (+white)
// word, sent MSB first with WS281x pulse-width timing. A data-low latch gap
// follows every frame.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   enable     1 = stream frames back to back; 0 = park in latch after the frame
//   level      brightness byte sent for every enabled channel
//   green/red/blue/white  per-LED channel enables (white ignored when RGBW=0)
//   data       strip serial data
//   busy       high for every cycle in which pixel bits are being sent
//   frame_done one-cycle pulse on the first latch cycle after a frame
module wled_stream #(
  parameter int CLK_MHZ     = 27,
  parameter int NUM_LEDS    = 1,
  parameter int COLOR_ORDER = 0,
  parameter int RGBW        = 0,
  parameter int T0H_NS      = 400,
  parameter int T1H_NS      = 800,
  parameter int TBIT_NS     = 1250,
  parameter int RESET_US    = 60
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [7:0]          level,
  input  logic [NUM_LEDS-1:0] green,
  input  logic [NUM_LEDS-1:0] red,
  input  logic [NUM_LEDS-1:0] blue,
  input  logic [NUM_LEDS-1:0] white,
  output logic                data,
  output logic                busy,
  output logic                frame_done
);

  localparam int T0H_CYC  = CLK_MHZ * T0H_NS / 1000;
  localparam int T1H_CYC  = CLK_MHZ * T1H_NS / 1000;
  localparam int TBIT_CYC = CLK_MHZ * TBIT_NS / 1000;
  localparam int RST_CYC  = CLK_MHZ * RESET_US;
  localparam int BPL      = 24 + 8 * RGBW;

  localparam int LAT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int BC_W  = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;
  localparam int BI_W  = $clog2(BPL);
  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RST_CYC - 1);
  localparam logic [BC_W-1:0]  TBIT_LAST = BC_W'(TBIT_CYC - 1);
  localparam logic [BC_W-1:0]  T0H_LEN   = BC_W'(T0H_CYC);
  localparam logic [BC_W-1:0]  T1H_LEN   = BC_W'(T1H_CYC);
  localparam logic [BI_W-1:0]  BIT_FIRST = BI_W'(BPL - 1);
  localparam logic [LED_W-1:0] LED_LAST  = LED_W'(NUM_LEDS - 1);

  generate
    if (T1H_CYC >= TBIT_CYC || T0H_CYC == 0) begin : g_bad_timing
      $error("wled_stream: timing needs T0H_CYC > 0 and T1H_CYC < TBIT_CYC");
    end
  endgenerate

  typedef enum logic {LATCH = 1'b0, SEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [BC_W-1:0]     bit_cyc_q, bit_cyc_d;
  logic [BI_W-1:0]     bit_idx_q, bit_idx_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic [LED_W-1:0]    led_nxt;
  logic [BPL-1:0]      word_q, word_d;
  logic [NUM_LEDS-1:0] g_q, g_d, r_q, r_d, b_q, b_d, w_q, w_d;
  logic [7:0]          lvl_q, lvl_d;
  logic                done_q, done_d;
  logic [BC_W-1:0]     high_len;

  // Builds one LED's wire word: colour bytes in wire order, then white.
  // The 32-bit staging word is shifted down so a 24-bit build drops the
  // (always zero) white byte.
  function automatic logic [BPL-1:0] compose(input logic g, input logic r,
                                             input logic b, input logic w,
                                             input logic [7:0] lv);
    logic [7:0]  gb, rb, bb, wb;
    logic [31:0] full;
    gb   = g ? lv : 8'h00;
    rb   = r ? lv : 8'h00;
    bb   = b ? lv : 8'h00;
    wb   = (RGBW != 0 && w) ? lv : 8'h00;
    full = (COLOR_ORDER == 0) ? {gb, rb, bb, wb} : {rb, gb, bb, wb};
    return BPL'(full >> (32 - BPL));
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LATCH;
      lat_cnt_q <= '0;
      bit_cyc_q <= '0;
      bit_idx_q <= '0;
      led_q     <= '0;
      word_q    <= '0;
      g_q       <= '0;
      r_q       <= '0;
      b_q       <= '0;
      w_q       <= '0;
      lvl_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      bit_cyc_q <= bit_cyc_d;
      bit_idx_q <= bit_idx_d;
      led_q     <= led_d;
      word_q    <= word_d;
      g_q       <= g_d;
      r_q       <= r_d;
      b_q       <= b_d;
      w_q       <= w_d;
      lvl_q     <= lvl_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    bit_cyc_d = bit_cyc_q;
    bit_idx_d = bit_idx_q;
    led_d     = led_q;
    word_d    = word_q;
    g_d       = g_q;
    r_d       = r_q;
    b_d       = b_q;
    w_d       = w_q;
    lvl_d     = lvl_q;
    done_d    = 1'b0;
    led_nxt   = led_q + LED_W'(1);
    high_len  = word_q[BPL-1] ? T1H_LEN : T0H_LEN;

    // Outputs decode the current state directly so data rises on the very
    // first SEND cycle and drops on the cycle a reset is taken.
    busy       = (state_q == SEND);
    data       = (state_q == SEND) && (bit_cyc_q < high_len);
    frame_done = done_q;

    case (state_q)
      LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          // Counter saturates here until enable is seen.
          if (enable) begin
            state_d   = SEND;
            g_d       = green;
            r_d       = red;
            b_d       = blue;
            w_d       = white;
            lvl_d     = level;
            // LED 0 is built from the live inputs since the snapshot
            // registers are only being loaded on this same edge.
            word_d    = compose(green[0], red[0], blue[0], white[0], level);
            bit_cyc_d = '0;
            bit_idx_d = BIT_FIRST;
            led_d     = '0;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      SEND: begin
        if (bit_cyc_q == TBIT_LAST) begin
          bit_cyc_d = '0;
          if (bit_idx_q == '0) begin
            bit_idx_d = BIT_FIRST;
            if (led_q == LED_LAST) begin
              state_d   = LATCH;
              lat_cnt_d = '0;
              led_d     = '0;
              done_d    = 1'b1;
            end else begin
              led_d  = led_nxt;
              word_d = compose(g_q[led_nxt], r_q[led_nxt], b_q[led_nxt],
                               w_q[led_nxt], lvl_q);
            end
          end else begin
            bit_idx_d = bit_idx_q - BI_W'(1);
            word_d    = {word_q[BPL-2:0], 1'b0};
          end
        end else begin
          bit_cyc_d = bit_cyc_q + BC_W'(1);
        end
      end
      default: state_d = LATCH;
    endcase
  end

endmodule

// File: tb/tb_wled_stream.sv
// tb_wled_stream: bench for wled_stream.
// Two instances at 10 MHz, 2 LEDs (T0H=4, T1H=8, TBIT=12, latch=600 cycles):
// instance 0 is GRB 24-bit and instance 1 is RGB + white, 32-bit. Only one
// instance runs at a time; the other is held in reset. A table of colour
// vectors carries the expected wire streams for both byte layouts. When a
// vector is driven, its expected bits go into a queue. The waveform decoder
// pops one expected bit per measured pulse.
module tb_wled_stream;

  logic       clk = 1'b0;
  logic [1:0] rst_n_v;
  logic [1:0] enable_v;
  logic [7:0] level;
  logic [1:0] green, red, blue, white;
  logic       data_w [2];
  logic       busy_w [2];
  logic       fd_w   [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    wled_stream #(
      .CLK_MHZ    (10),
      .NUM_LEDS   (2),
      .COLOR_ORDER(gi),
      .RGBW       (gi),
      .T0H_NS     (400),
      .T1H_NS     (800),
      .TBIT_NS    (1250),
      .RESET_US   (60)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n_v[gi]),
      .enable    (enable_v[gi]),
      .level     (level),
      .green     (green),
      .red       (red),
      .blue      (blue),
      .white     (white),
      .data      (data_w[gi]),
      .busy      (busy_w[gi]),
      .frame_done(fd_w[gi])
    );
  end

  typedef struct {
    logic [1:0]  g, r, b, w;
    logic [7:0]  lv;
    logic [47:0] exp_a;  // GRB, LED0 word then LED1 word
    logic [63:0] exp_b;  // RGBW, LED0 word then LED1 word
  } vec_t;

  vec_t vecs [5];
  bit   exp_q [$];

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   sel = 0;
  int   hc = 0, lc = 0;
  int   t_rise = 0, t_done = 0;
  bit   in_bit = 0, rise_evt = 0, done_evt = 0;
  logic prev_d = 0, prev_b = 0, prev_f = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (dut %0d, cycle %0d)",
                  name, act, exp, sel, cyc);
  endtask

  task automatic push_exp(input int k);
    if (sel == 0) for (int i = 47; i >= 0; i--) exp_q.push_back(vecs[k].exp_a[i]);
    else          for (int i = 63; i >= 0; i--) exp_q.push_back(vecs[k].exp_b[i]);
  endtask

  task automatic apply(input int k);
    green = vecs[k].g;
    red   = vecs[k].r;
    blue  = vecs[k].b;
    white = vecs[k].w;
    level = vecs[k].lv;
    push_exp(k);
  endtask

  task automatic finish_bit();
    bit e;
    check("bit_expected_pending", int'(exp_q.size() > 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("bit_high_cycles", hc, e ? 8 : 4);
    check("bit_low_cycles", lc, e ? 4 : 8);
  endtask

  // One clock: sample the active instance on the falling edge and decode.
  task automatic step();
    logic d, b, f, r;
    @(negedge clk);
    cyc++;
    rise_evt = 1'b0;
    done_evt = 1'b0;
    d = data_w[sel];
    b = busy_w[sel];
    f = fd_w[sel];
    r = rst_n_v[sel];
    if (!r) begin
      in_bit = 1'b0;
      hc = 0;
      lc = 0;
    end else begin
      if (b && !prev_b) begin
        rise_evt = 1'b1;
        t_rise = cyc;
      end
      if (prev_f) check("frame_done_width", f, 0);
      if (d && !prev_d) begin
        if (in_bit) finish_bit();
        in_bit = 1'b1;
        hc = 1;
        lc = 0;
      end else if (in_bit && d) begin
        hc++;
      end else if (in_bit && b) begin
        lc++;
      end
      if (f) begin
        if (in_bit) finish_bit();
        in_bit = 1'b0;
        done_evt = 1'b1;
        t_done = cyc;
        $display("dut %0d frame done at cycle %0d (%0d send cycles)",
                 sel, cyc, cyc - t_rise);
      end
    end
    prev_d = d;
    prev_b = b;
    prev_f = f;
  endtask

  task automatic rise_latency(input string name);
    int n = 0;
    while (!data_w[sel] && n < 700) begin
      step();
      n++;
    end
    check(name, n, 600);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      step();
      n++;
    end while (!done_evt && n < 2000);
    check("frame_done_seen", int'(done_evt), 1);
  endtask

  task automatic wait_rise();
    int n = 0;
    do begin
      step();
      n++;
    end while (!rise_evt && n < 1000);
    check("frame_start_seen", int'(rise_evt), 1);
  endtask

  initial begin
    int n;
    int send_len;
    vecs[0] = '{g: 2'b01, r: 2'b00, b: 2'b00, w: 2'b00, lv: 8'hFF,
                exp_a: 48'hFF0000_000000, exp_b: 64'h00FF0000_00000000};
    vecs[1] = '{g: 2'b00, r: 2'b10, b: 2'b00, w: 2'b00, lv: 8'hA5,
                exp_a: 48'h000000_00A500, exp_b: 64'h00000000_A5000000};
    vecs[2] = '{g: 2'b11, r: 2'b01, b: 2'b10, w: 2'b01, lv: 8'h3C,
                exp_a: 48'h3C3C00_3C003C, exp_b: 64'h3C3C003C_003C3C00};
    vecs[3] = '{g: 2'b11, r: 2'b11, b: 2'b11, w: 2'b11, lv: 8'h00,
                exp_a: 48'h000000_000000, exp_b: 64'h00000000_00000000};
    vecs[4] = '{g: 2'b01, r: 2'b01, b: 2'b00, w: 2'b10, lv: 8'h80,
                exp_a: 48'h808000_000000, exp_b: 64'h80800000_00000080};

    rst_n_v  = 2'b00;
    enable_v = 2'b00;

    for (int s = 0; s < 2; s++) begin
      sel      = s;
      send_len = 2 * (24 + 8 * s) * 12;
      rst_n_v  = 2'b00;
      enable_v = 2'b00;
      exp_q.delete();
      apply(0);
      repeat (5) step();
      check("reset_data", data_w[s], 0);
      check("reset_busy", busy_w[s], 0);
      check("reset_frame_done", fd_w[s], 0);

      rst_n_v[s]  = 1'b1;
      enable_v[s] = 1'b1;
      rise_latency("first_rise_latency");

      // Frame k carries vecs[k]; the next vector is driven mid-frame.
      for (int k = 0; k < 5; k++) begin
        repeat (100) step();
        if (k < 4) apply(k + 1);
        else enable_v[s] = 1'b0;
        wait_done();
        check("send_length", t_done - t_rise, send_len);
        if (k < 4) begin
          wait_rise();
          check("latch_gap", t_rise - t_done, 600);
        end
      end

      n = 0;
      repeat (1000) begin
        step();
        if (data_w[s] || busy_w[s]) n++;
      end
      check("idle_activity_cycles", n, 0);
      check("queue_drained", exp_q.size(), 0);

      // Re-enable from a saturated latch, then abort mid '1' high phase.
      push_exp(4);
      enable_v[s] = 1'b1;
      step();
      check("reenable_busy", busy_w[s], 1);
      check("reenable_data", data_w[s], 1);
      repeat (2) step();
      check("high_before_reset", data_w[s], 1);
      rst_n_v[s] = 1'b0;
      step();
      check("abort_data", data_w[s], 0);
      check("abort_busy", busy_w[s], 0);
      exp_q.delete();
      push_exp(4);
      repeat (3) step();
      rst_n_v[s] = 1'b1;
      rise_latency("rise_after_reset");
      repeat (100) step();
      enable_v[s] = 1'b0;
      wait_done();
      check("send_length_after_reset", t_done - t_rise, send_len);
      repeat (700) step();
      check("queue_drained_final", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
